// File: rtl/ahblite_copy_master.sv
// AHB-Lite master copying len words src->dst, one SINGLE read then one SINGLE write per word.
// Latency 4 cycles/word with zero wait states; HREADY low stalls the current phase, HRESP aborts.
module ahblite_copy_master (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_D = 3'd2;
  localparam logic [2:0] WR_A = 3'd3;
  localparam logic [2:0] WR_D = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]  state;
  logic [31:0] src_ptr;
  logic [31:0] dst_ptr;
  logic [31:0] word_buf;
  logic [15:0] count;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      src_ptr  <= 32'h0;
      dst_ptr  <= 32'h0;
      word_buf <= 32'h0;
      count    <= 16'h0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (len == 16'h0) begin
              state <= DONE;
            end else begin
              src_ptr <= src_addr & 32'hFFFF_FFFC;
              dst_ptr <= dst_addr & 32'hFFFF_FFFC;
              count   <= len;
              state   <= RD_A;
            end
          end
        end
        RD_A: if (HREADY) state <= RD_D;
        RD_D: begin
          // ERROR is taken on its first (HREADY low) cycle; ERR waits out the second.
          if (HRESP) begin
            state <= ERR;
          end else if (HREADY) begin
            word_buf <= HRDATA;
            state    <= WR_A;
          end
        end
        WR_A: if (HREADY) state <= WR_D;
        WR_D: begin
          if (HRESP) begin
            state <= ERR;
          end else if (HREADY) begin
            src_ptr <= src_ptr + 32'd4;
            dst_ptr <= dst_ptr + 32'd4;
            count   <= count - 16'd1;
            state   <= (count == 16'd1) ? DONE : RD_A;
          end
        end
        ERR: begin
          if (HREADY) begin
            error <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every bus output is a pure decode of registered state.
  assign busy      = (state == RD_A) || (state == RD_D) || (state == WR_A) ||
                     (state == WR_D) || (state == ERR);
  assign done      = (state == DONE);
  assign HTRANS    = ((state == RD_A) || (state == WR_A)) ? 2'b10 : 2'b00;
  assign HADDR     = (state == RD_A) ? src_ptr : ((state == WR_A) ? dst_ptr : 32'h0);
  assign HWRITE    = (state == WR_A);
  assign HWDATA    = word_buf;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_copy_master.sv
// Directed bench for ahblite_copy_master with a behavioural AHB-Lite slave memory.
module tb_ahblite_copy_master;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len = 16'h0;
  logic        busy, done, error;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  ahblite_copy_master dut (
    .clk(clk), .RSTn(RSTn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .error(error), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(17 * (i + 1));
    return {4{b}};
  endfunction

  // Slave model state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] tr_addr [$];
  bit          tr_wr [$];
  int          wait_n = 0;
  int          err_rd = -1;
  int          rd_idx = 0;
  int          unstable = 0;
  bit          dp_active = 0, dp_write = 0, dp_err = 0, dp_first = 0;
  int          wait_left = 0, err_stage = 0;
  logic [31:0] dp_addr = 0, wd0 = 0;

  // Slave reacts mid-cycle; DUT outputs are registered so negedge values are final.
  initial begin
    forever begin
      @(negedge clk);
      if (!RSTn) begin
        dp_active = 0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        if (dp_active) begin
          if (dp_write) begin
            if (dp_first) wd0 = HWDATA;
            else if (HWDATA !== wd0) unstable++;
          end
          dp_first = 0;
          if (dp_err) begin
            if (err_stage == 0) begin HREADY = 1'b0; HRESP = 1'b1; err_stage = 1; end
            else begin HREADY = 1'b1; HRESP = 1'b1; dp_active = 0; end
          end else if (wait_left > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; wait_left--;
          end else begin
            HREADY = 1'b1; HRESP = 1'b0; dp_active = 0;
            if (dp_write) mem[dp_addr] = HWDATA;
            else HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : 32'hDEAD_BEEF;
          end
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
          tr_addr.push_back(HADDR);
          tr_wr.push_back(HWRITE);
          dp_active = 1; dp_write = HWRITE; dp_addr = HADDR; dp_first = 1;
          wait_left = wait_n; err_stage = 0;
          dp_err = !HWRITE && (rd_idx == err_rd);
          if (!HWRITE) rd_idx++;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          wait_n;
    int          err_rd;
    int          poke;
    int          exp_done;
    bit          exp_err;
    int          exp_xfers;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input int id);
    int  first_done, n_done, n_busy;
    bit  err_at;
    string t;
    t = $sformatf("v%0d", id);
    mem.delete(); tr_addr.delete(); tr_wr.delete();
    unstable = 0; rd_idx = 0; wait_n = v.wait_n; err_rd = v.err_rd;
    for (int i = 0; i < int'(v.len); i++) mem[v.src + 32'(4 * i)] = pat(i);
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_done = -1; n_done = 0; n_busy = 0; err_at = 0;
    for (int c = 1; c <= 30; c++) begin
      start = (c == v.poke);
      if (done) begin
        n_done++;
        if (first_done < 0) begin first_done = c; err_at = error; end
      end
      if (busy) n_busy++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({t, " done_cycle"}, 32'(first_done), 32'(v.exp_done));
    chk({t, " error"}, 32'(err_at), 32'(v.exp_err));
    chk({t, " done_pulses"}, 32'(n_done), 32'd1);
    chk({t, " busy_cycles"}, 32'(n_busy), 32'(v.exp_done - 1));
    chk({t, " n_transfers"}, 32'(tr_addr.size()), 32'(v.exp_xfers));
    for (int j = 0; j < v.exp_xfers && j < tr_addr.size(); j++) begin
      chk($sformatf("%s xfer%0d_write", t, j), 32'(tr_wr[j]), 32'(j % 2));
      chk($sformatf("%s xfer%0d_addr", t, j), tr_addr[j],
          ((j % 2) ? v.dst : v.src) + 32'(4 * (j / 2)));
    end
    for (int k = 0; k < v.exp_xfers / 2; k++)
      chk($sformatf("%s dst_word%0d", t, k),
          mem.exists(v.dst + 32'(4 * k)) ? mem[v.dst + 32'(4 * k)] : 32'hBAD0_BAD0, pat(k));
    if (v.exp_err)
      chk({t, " no_extra_write"}, 32'(mem.exists(v.dst + 32'(4 * (v.exp_xfers / 2)))), 32'd0);
    chk({t, " hwdata_stable"}, 32'(unstable), 32'd0);
    chk({t, " error_held"}, 32'(error), 32'(v.exp_err));
    chk({t, " htrans_idle_after"}, 32'(HTRANS), 32'd0);
  endtask

  initial begin
    int n_done;
    vecs[0] = '{32'h2000_0000, 32'h2000_0100, 16'd3, 0, -1, 0, 13, 1'b0, 6};
    vecs[1] = '{32'h2000_0200, 32'h2000_0300, 16'd1, 2, -1, 0,  9, 1'b0, 2};
    vecs[2] = '{32'h2000_0000, 32'h2000_0400, 16'd2, 0,  1, 0,  8, 1'b1, 3};
    vecs[3] = '{32'h2000_0600, 32'h2000_0700, 16'd0, 0, -1, 0,  1, 1'b0, 0};
    vecs[4] = '{32'hFFFF_FFFC, 32'h2000_0500, 16'd2, 0, -1, 0,  9, 1'b0, 4};
    vecs[5] = '{32'h2000_0800, 32'h2000_0900, 16'd2, 0, -1, 3,  9, 1'b0, 4};
    vecs[6] = '{32'h2000_0A00, 32'h2000_0B00, 16'd2, 0, -1, 9,  9, 1'b0, 4};

    #2;
    chk("rst HTRANS", 32'(HTRANS), 32'd0);
    chk("rst HADDR", HADDR, 32'h0);
    chk("rst HWRITE", 32'(HWRITE), 32'd0);
    chk("rst HWDATA", HWDATA, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("const HSIZE", 32'(HSIZE), 32'd2);
    chk("const HBURST", 32'(HBURST), 32'd0);
    chk("const HPROT", 32'(HPROT), 32'd3);
    chk("const HMASTLOCK", 32'(HMASTLOCK), 32'd0);
    @(negedge clk);
    @(negedge clk);
    RSTn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset asserted during WR_A of the first word.
    mem.delete(); tr_addr.delete(); tr_wr.delete();
    wait_n = 0; err_rd = -1; rd_idx = 0;
    mem[32'h2000_0C00] = pat(0); mem[32'h2000_0C04] = pat(1);
    @(negedge clk);
    src_addr = 32'h2000_0C00; dst_addr = 32'h2000_0D00; len = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid in WR_A HTRANS", 32'(HTRANS), 32'h2);
    chk("rstmid in WR_A HWRITE", 32'(HWRITE), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("rstmid HTRANS", 32'(HTRANS), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) RSTn = 1'b1;
      if (done) n_done++;
    end
    chk("rstmid done_pulses", 32'(n_done), 32'd0);
    chk("rstmid busy_after", 32'(busy), 32'd0);
    chk("rstmid no_write", 32'(mem.exists(32'h2000_0D00)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
